// File: rtl/par_word_serializer_tx.sv
// Parallel-word to serial transmitter with frame qualifier and done pulse.
// Optional even-parity trailer bit when TX_PARITY_EN is defined.
module par_word_serializer_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             ser_out,
  output logic             frame,
  output logic             done
);

`ifdef TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_n;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  logic             r_ready;
  logic             w_ready_n;
  logic             r_ser;
  logic             w_ser_n;
  logic             r_frame;
  logic             w_frame_n;
  logic             r_done;
  logic             w_done_n;
  logic             w_last;
  logic             w_head;
  logic             w_first;
  logic [WIDTH-1:0] w_load_sh;
  logic [WIDTH-1:0] w_step_sh;
`ifdef TX_PARITY_EN
  logic             r_par;
  logic             w_par_n;
`endif

  assign w_last = (r_cnt == '0);

  // First bit goes straight to ser_out; the rest stay in the shifter.
  assign w_first   = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign w_load_sh = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
  assign w_head    = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
  assign w_step_sh = MSB_FIRST ? (r_sh << 1) : (r_sh >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (load)   w_state_n = S_SHIFT;
      S_SHIFT: if (w_last) w_state_n = S_DONE;
      S_DONE:              w_state_n = S_IDLE;
      default:             w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_sh_n    = r_sh;
    w_cnt_n   = r_cnt;
    w_ser_n   = 1'b0;
    w_frame_n = 1'b0;
    w_done_n  = 1'b0;
    w_ready_n = 1'b0;
`ifdef TX_PARITY_EN
    w_par_n   = r_par;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_ready_n = 1'b1;
        if (load) begin
          w_ready_n = 1'b0;
          w_frame_n = 1'b1;
          w_ser_n   = w_first;
          w_sh_n    = w_load_sh;
          w_cnt_n   = CW'(NBITS - 1);
`ifdef TX_PARITY_EN
          w_par_n   = ^data_in;
`endif
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_done_n = 1'b1;
        end else begin
          w_frame_n = 1'b1;
          w_ser_n   = w_head;
          w_sh_n    = w_step_sh;
          w_cnt_n   = r_cnt - CW'(1);
`ifdef TX_PARITY_EN
          if (r_cnt == CW'(1)) w_ser_n = r_par;
`endif
        end
      end
      S_DONE: begin
        w_ready_n = 1'b1;
      end
      default: begin
        w_ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh    <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b1;
      r_ser   <= 1'b0;
      r_frame <= 1'b0;
      r_done  <= 1'b0;
`ifdef TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_sh    <= w_sh_n;
      r_cnt   <= w_cnt_n;
      r_ready <= w_ready_n;
      r_ser   <= w_ser_n;
      r_frame <= w_frame_n;
      r_done  <= w_done_n;
`ifdef TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  assign ready   = r_ready;
  assign ser_out = r_ser;
  assign frame   = r_frame;
  assign done    = r_done;

endmodule
